// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file with byte-enable writes, bypass, HI/LO pair and busy scoreboard
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int AW       = $clog2(NUM_REGS) + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NRD*AW-1:0]          rd_addr,
  output logic [NRD*DATA_W-1:0]      rd_data,
  output logic [NRD-1:0]             rd_busy,
  input  logic [NWR-1:0]             wr_en,
  input  logic [NWR*AW-1:0]          wr_addr,
  input  logic [NWR*DATA_W-1:0]      wr_data,
  input  logic [NWR*(DATA_W/8)-1:0]  wr_be,
  input  logic                       hl_we,
  input  logic [2*DATA_W-1:0]        hl_data,
  input  logic                       iss_valid,
  input  logic [AW-1:0]              iss_addr,
  input  logic                       sb_flush
);

  localparam int NB = DATA_W / 8;
  localparam int IW = AW - 2;
  // Storage slots: GPRs at 0..NUM_REGS-1, then LO and HI.
  localparam int NE = NUM_REGS + 2;
  localparam int KW = $clog2(NE);
  localparam logic [KW-1:0] LO_K = KW'(NUM_REGS);
  localparam logic [KW-1:0] HI_K = KW'(NUM_REGS + 1);

  logic [DATA_W-1:0] mem [NE];
  logic [NE-1:0]     busy;

  logic [KW-1:0]     wk [NWR];
  logic [NWR-1:0]    wv;
  logic [KW-1:0]     rk [NRD];
  logic [NRD-1:0]    rv;
  logic [KW-1:0]     ik;
  logic              iv;
  logic [NB-1:0]     cov;
  logic [7:0]        byt;

  // Map an address to {valid, slot}; GPR0 and the CP0 space are not valid slots.
  function automatic logic [KW:0] decode(input logic [AW-1:0] a);
    logic [KW:0] r;
    r = '0;
    case (a[AW-1 -: 2])
      2'b00:   r = {(a[IW-1:0] != '0), KW'(a[IW-1:0])};
      2'b10:   r = {1'b1, LO_K};
      2'b11:   r = {1'b1, HI_K};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Decode every write, read and issue address to a storage slot.
  always_comb begin
    wv = '0;
    rv = '0;
    for (int p = 0; p < NWR; p++) begin
      wk[p] = '0;
      {wv[p], wk[p]} = decode(wr_addr[p*AW +: AW]);
    end
    for (int k = 0; k < NRD; k++) begin
      rk[k] = '0;
      {rv[k], rk[k]} = decode(rd_addr[k*AW +: AW]);
    end
    {iv, ik} = decode(iss_addr);
  end

  // Storage and scoreboard update; later statements take precedence over earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) mem[i] <= '0;
      busy <= '0;
    end else begin
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && wv[p]) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[p*NB + b]) mem[wk[p]][b*8 +: 8] <= wr_data[p*DATA_W + b*8 +: 8];
          end
          busy[wk[p]] <= 1'b0;
        end
      end
      if (hl_we) begin
        mem[LO_K]  <= hl_data[DATA_W-1:0];
        mem[HI_K]  <= hl_data[2*DATA_W-1:DATA_W];
        busy[LO_K] <= 1'b0;
        busy[HI_K] <= 1'b0;
      end
      if (iss_valid && iv) busy[ik] <= 1'b1;
      if (sb_flush) busy <= '0;
    end
  end

  // Per-byte read mux; the paired HI/LO write is applied last so the bypass shows exactly what gets stored.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    cov     = '0;
    byt     = '0;
    for (int k = 0; k < NRD; k++) begin
      cov = '0;
      if (rv[k]) begin
        for (int b = 0; b < NB; b++) begin
          byt = mem[rk[k]][b*8 +: 8];
          for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && wv[p] && (wk[p] == rk[k]) && wr_be[p*NB + b]) begin
              byt    = wr_data[p*DATA_W + b*8 +: 8];
              cov[b] = 1'b1;
            end
          end
          if (hl_we && (rk[k] == LO_K)) begin
            byt    = hl_data[b*8 +: 8];
            cov[b] = 1'b1;
          end
          if (hl_we && (rk[k] == HI_K)) begin
            byt    = hl_data[DATA_W + b*8 +: 8];
            cov[b] = 1'b1;
          end
          rd_data[k*DATA_W + b*8 +: 8] = byt;
        end
        rd_busy[k] = busy[rk[k]] && !(&cov);
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp with directed and random stimulus
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW = 7;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*AW-1:0]     wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic [NWR*NB-1:0]     wr_be;
  logic                  hl_we;
  logic [2*DATA_W-1:0]   hl_data;
  logic                  iss_valid;
  logic [AW-1:0]         iss_addr;
  logic                  sb_flush;

  regfile_mp #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NRD(NRD), .NWR(NWR), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .hl_we(hl_we), .hl_data(hl_data), .iss_valid(iss_valid), .iss_addr(iss_addr),
    .sb_flush(sb_flush)
  );

  typedef struct {
    logic [NRD*DATA_W-1:0] data;
    logic [NRD-1:0]        busy;
    string                 name;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // Reference model: architectural registers and pending-write flags.
  logic [31:0]         m_gpr [NUM_REGS];
  logic [31:0]         m_lo, m_hi;
  bit [NUM_REGS-1:0]   m_bgpr;
  bit                  m_blo, m_bhi;

  function automatic logic [AW-1:0] gpr(input int i);
    return {2'b00, 5'(i)};
  endfunction
  function automatic logic [AW-1:0] lo_a();
    return {2'b10, 5'($urandom)};
  endfunction
  function automatic logic [AW-1:0] hi_a();
    return {2'b11, 5'($urandom)};
  endfunction
  function automatic logic [AW-1:0] cp0_a();
    return {2'b01, 5'($urandom)};
  endfunction
  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 9))
      0: return gpr(0);
      1, 2, 3, 4: return gpr($urandom_range(1, 4));
      5: return gpr(31);
      6: return lo_a();
      7: return hi_a();
      8: return cp0_a();
      default: return gpr($urandom_range(0, 31));
    endcase
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_gpr[i] = '0;
    m_lo = '0; m_hi = '0; m_bgpr = '0; m_blo = 0; m_bhi = 0;
  endtask

  task automatic idle();
    rst = 0; wr_en = '0; hl_we = 0; iss_valid = 0; sb_flush = 0;
    wr_addr = '0; wr_data = '0; wr_be = '0; hl_data = '0; iss_addr = '0;
  endtask

  // Predict this cycle's reads, queue them, commit the model, advance one clock.
  task automatic step(input bit chk, input string nm);
    logic [31:0] n_gpr [NUM_REGS];
    logic [3:0]  c_gpr [NUM_REGS];
    logic [31:0] n_lo, n_hi;
    logic [3:0]  c_lo, c_hi;
    bit [NUM_REGS-1:0] nb_gpr;
    bit nb_lo, nb_hi;
    logic [AW-1:0] a;
    logic [31:0] d;
    logic [3:0] be;
    exp_t e;
    n_gpr = m_gpr; n_lo = m_lo; n_hi = m_hi;
    for (int i = 0; i < NUM_REGS; i++) c_gpr[i] = '0;
    c_lo = '0; c_hi = '0;
    nb_gpr = m_bgpr; nb_lo = m_blo; nb_hi = m_bhi;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p]) begin
        a = wr_addr[p*AW +: AW]; d = wr_data[p*32 +: 32]; be = wr_be[p*NB +: NB];
        if (a[6:5] == 2'b00 && a[4:0] != 0) begin
          n_gpr[a[4:0]] = merge(n_gpr[a[4:0]], d, be);
          c_gpr[a[4:0]] |= be;
          nb_gpr[a[4:0]] = 0;
        end else if (a[6:5] == 2'b10) begin
          n_lo = merge(n_lo, d, be); c_lo |= be; nb_lo = 0;
        end else if (a[6:5] == 2'b11) begin
          n_hi = merge(n_hi, d, be); c_hi |= be; nb_hi = 0;
        end
      end
    end
    if (hl_we) begin
      n_lo = hl_data[31:0]; n_hi = hl_data[63:32];
      c_lo = 4'hF; c_hi = 4'hF; nb_lo = 0; nb_hi = 0;
    end
    if (iss_valid) begin
      if (iss_addr[6:5] == 2'b00 && iss_addr[4:0] != 0) nb_gpr[iss_addr[4:0]] = 1;
      else if (iss_addr[6:5] == 2'b10) nb_lo = 1;
      else if (iss_addr[6:5] == 2'b11) nb_hi = 1;
    end
    if (sb_flush) begin
      nb_gpr = '0; nb_lo = 0; nb_hi = 0;
    end
    e.data = '0; e.busy = '0; e.name = nm;
    for (int k = 0; k < NRD; k++) begin
      a = rd_addr[k*AW +: AW];
      if (a[6:5] == 2'b00 && a[4:0] != 0) begin
        e.data[k*32 +: 32] = n_gpr[a[4:0]];
        e.busy[k] = m_bgpr[a[4:0]] && (c_gpr[a[4:0]] != 4'hF);
      end else if (a[6:5] == 2'b10) begin
        e.data[k*32 +: 32] = n_lo;
        e.busy[k] = m_blo && (c_lo != 4'hF);
      end else if (a[6:5] == 2'b11) begin
        e.data[k*32 +: 32] = n_hi;
        e.busy[k] = m_bhi && (c_hi != 4'hF);
      end
    end
    if (chk) q.push_back(e);
    if (rst) model_reset();
    else begin
      m_gpr = n_gpr; m_lo = n_lo; m_hi = n_hi;
      m_bgpr = nb_gpr; m_blo = nb_lo; m_bhi = nb_hi;
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  // Monitor: compare the DUT's combinational outputs mid-cycle against the oldest prediction.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (rd_data !== e.data) begin
          failures++;
          $display("FAIL %s rd_data got=%h exp=%h (addr=%h)", e.name, rd_data, e.data, rd_addr);
        end
        checks++;
        if (rd_busy !== e.busy) begin
          failures++;
          $display("FAIL %s rd_busy got=%b exp=%b (addr=%h)", e.name, rd_busy, e.busy, rd_addr);
        end
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    rd_addr = '0;
    model_reset();
    step(0, "reset");
    step(0, "idle");

    for (int a = 0; a < 128; a++) begin
      rd_addr = {7'($urandom), 7'(a)};
      step(1, "reset_read");
    end

    wr_en = 2'b11; wr_addr = {gpr(5), gpr(5)};
    wr_data = {32'hAABBCCDD, 32'h11223344}; wr_be = {4'b0011, 4'b1111};
    rd_addr = {gpr(5), gpr(5)};
    step(1, "byte_merge_bypass");
    step(1, "byte_merge_stored");

    iss_valid = 1; iss_addr = gpr(7); rd_addr = {gpr(7), gpr(7)};
    step(1, "issue_r7");
    step(1, "busy_r7");
    wr_en = 2'b01; wr_addr = {gpr(1), gpr(7)}; wr_data = {32'h0, 32'hCAFEF00D}; wr_be = {4'h0, 4'hF};
    iss_valid = 1; iss_addr = gpr(7);
    step(1, "wr_iss_same");
    step(1, "busy_kept");
    wr_en = 2'b01; wr_addr = {gpr(1), gpr(7)}; wr_data = {32'h0, 32'h55555555}; wr_be = '0;
    step(1, "be0_clear");
    step(1, "busy_cleared");

    hl_we = 1; hl_data = {32'hDEAD0000, 32'h0000BEEF};
    wr_en = 2'b01; wr_addr = {gpr(1), lo_a()}; wr_data = {32'h0, 32'h12345678}; wr_be = {4'h0, 4'hF};
    rd_addr = {hi_a(), lo_a()};
    step(1, "hl_override");
    step(1, "hl_stored");

    wr_en = 2'b11; wr_addr = {cp0_a(), gpr(0)}; wr_data = '1; wr_be = '1;
    iss_valid = 1; iss_addr = gpr(0); rd_addr = {cp0_a(), gpr(0)};
    step(1, "zero_write");
    iss_valid = 1; iss_addr = cp0_a();
    step(1, "zero_stored");
    step(1, "zero_busy");

    iss_valid = 1; iss_addr = gpr(3); step(0, "iss_r3");
    iss_valid = 1; iss_addr = hi_a(); step(0, "iss_hi");
    iss_valid = 1; iss_addr = gpr(31); rd_addr = {hi_a(), gpr(3)}; step(1, "iss_r31");
    rd_addr = {gpr(31), gpr(3)}; step(1, "busy_set");
    sb_flush = 1; iss_valid = 1; iss_addr = gpr(4); rd_addr = {gpr(4), gpr(3)};
    step(1, "flush");
    rd_addr = {gpr(4), gpr(3)}; step(1, "flush_r3_r4");
    rd_addr = {hi_a(), gpr(31)}; step(1, "flush_hi_r31");

    rst = 1; wr_en = 2'b01; wr_addr = {gpr(1), gpr(9)}; wr_data = {32'h0, 32'h99999999}; wr_be = '1;
    iss_valid = 1; iss_addr = gpr(9);
    step(0, "rst_with_write");
    rd_addr = {gpr(9), gpr(9)}; step(1, "rst_wins");

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NWR; p++) begin
        wr_en[p] = ($urandom_range(0, 2) != 0);
        wr_addr[p*AW +: AW] = rand_addr();
        wr_data[p*32 +: 32] = $urandom;
        wr_be[p*NB +: NB] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
      end
      hl_we = ($urandom_range(0, 7) == 0);
      hl_data = {$urandom, $urandom};
      iss_valid = ($urandom_range(0, 1) != 0);
      iss_addr = rand_addr();
      sb_flush = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = rand_addr();
      step(!rst, "random");
    end

    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
